// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and RAM-side signals of mem_port_arbiter.
// slave = arbiter view; master = requesters plus RAM view.
interface mem_port_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic              i_req;
    logic [AW-1:0]     i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DW-1:0]     i_rdata;

    logic              d_req;
    logic              d_we;
    logic [DW/8-1:0]   d_be;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DW-1:0]     d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [DW/8-1:0]   mem_be;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync RAM between instruction fetch and data ports.
// Define MEM_PORT_ARBITER_RR_EN for round-robin; default is data > fetch with anti-starvation.
module mem_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
        logic   we;
    } tag_t;

    logic   grant_i;
    logic   grant_d;
    tag_t   tag_q [MEM_LAT];
    tag_t   tag_new;
    tag_t   tail;

`ifdef MEM_PORT_ARBITER_RR_EN
    owner_t last_owner;
`else
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;
`endif

    // Grants are gated by rst so nothing reaches the RAM while reset is held.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!rst) begin
            if (bus.i_req && bus.d_req) begin
`ifdef MEM_PORT_ARBITER_RR_EN
                if (last_owner == OWN_DATA) grant_i = 1'b1;
                else                        grant_d = 1'b1;
`else
                if (starve_cnt == SW'(STARVE_MAX)) grant_i = 1'b1;
                else                               grant_d = 1'b1;
`endif
            end else if (bus.i_req) begin
                grant_i = 1'b1;
            end else if (bus.d_req) begin
                grant_d = 1'b1;
            end
        end
    end

    always_comb begin
        bus.i_gnt     = grant_i;
        bus.d_gnt     = grant_d;
        bus.mem_en    = grant_i | grant_d;
        bus.mem_we    = grant_d & bus.d_we;
        bus.mem_be    = (grant_d && bus.d_we) ? bus.d_be : '0;
        bus.mem_wdata = (grant_d && bus.d_we) ? bus.d_wdata : '0;
        bus.mem_addr  = grant_d ? bus.d_addr : (grant_i ? bus.i_addr : '0);
    end

    always_comb begin
        tag_new.valid = grant_i | grant_d;
        tag_new.owner = grant_d ? OWN_DATA : OWN_FETCH;
        tag_new.we    = grant_d & bus.d_we;
        tail          = tag_q[MEM_LAT-1];
    end

`ifdef MEM_PORT_ARBITER_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= OWN_DATA;
        end else if (grant_i) begin
            last_owner <= OWN_FETCH;
        end else if (grant_d) begin
            last_owner <= OWN_DATA;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (bus.i_req && !grant_i) begin
            starve_cnt <= starve_cnt + SW'(1);
        end else begin
            starve_cnt <= '0;
        end
    end
`endif

    // Tag pipeline tracks who owns each in-flight RAM access, in grant order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MEM_LAT; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0] <= tag_new;
            for (int k = 1; k < MEM_LAT; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.i_rvalid <= 1'b0;
            bus.d_rvalid <= 1'b0;
            bus.i_rdata  <= '0;
            bus.d_rdata  <= '0;
        end else begin
            bus.i_rvalid <= tail.valid && (tail.owner == OWN_FETCH);
            bus.d_rvalid <= tail.valid && (tail.owner == OWN_DATA);
            if (tail.valid && tail.owner == OWN_FETCH) bus.i_rdata <= bus.mem_rdata;
            if (tail.valid && tail.owner == OWN_DATA)
                bus.d_rdata <= tail.we ? '0 : bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2, STARVE_MAX=4 and a behavioural RAM.
module tb_mem_port_arbiter;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] pat(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | {22'd0, a};
    endfunction

    logic [31:0] ram   [1024];
    logic [31:0] rpipe [LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 1024; k++) ram[k] <= pat(AW'(k));
            ram[10'h010] <= 32'h0050_0093;
            ram[10'h020] <= 32'h1122_3344;
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
            rpipe[0] <= ram[bus.mem_addr];
        end
        for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
    end
    assign bus.mem_rdata = rpipe[LAT-1];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        bit          own_d;
        logic [31:0] data;
    } exp_t;
    exp_t expq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: check grants and any due response, then advance past the edge.
    task automatic cycle(input bit exp_i, input bit exp_d, input logic [31:0] d_exp, input string tag);
        exp_t e;
        bit ei, ed;
        logic [31:0] di, dd;
        ei = 1'b0; ed = 1'b0; di = '0; dd = '0;
        @(negedge clk);
        check({tag, "_i_gnt"}, 32'(bus.i_gnt), 32'(exp_i));
        check({tag, "_d_gnt"}, 32'(bus.d_gnt), 32'(exp_d));
        if (exp_i) expq.push_back('{cyc + LAT + 1, 1'b0, pat(bus.i_addr) });
        if (exp_i && bus.i_addr == 10'h010) expq[$].data = 32'h0050_0093;
        if (exp_d) expq.push_back('{cyc + LAT + 1, 1'b1, bus.d_we ? 32'h0 : d_exp});
        if (expq.size() > 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            if (e.own_d) begin ed = 1'b1; dd = e.data; end
            else         begin ei = 1'b1; di = e.data; end
        end
        check({tag, "_i_rvalid"}, 32'(bus.i_rvalid), 32'(ei));
        check({tag, "_d_rvalid"}, 32'(bus.d_rvalid), 32'(ed));
        if (ei) check({tag, "_i_rdata"}, bus.i_rdata, di);
        if (ed) check({tag, "_d_rdata"}, bus.d_rdata, dd);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        bit gi;
        bus.i_req   = 1'b1;
        bus.i_addr  = 10'h010;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_be    = 4'h0;
        bus.d_addr  = 10'h020;
        bus.d_wdata = '0;

        // reset held with both requesters active
        repeat (2) @(negedge clk);
        check("rst_i_gnt",    32'(bus.i_gnt),    0);
        check("rst_d_gnt",    32'(bus.d_gnt),    0);
        check("rst_i_rvalid", 32'(bus.i_rvalid), 0);
        check("rst_d_rvalid", 32'(bus.d_rvalid), 0);
        check("rst_mem_en",   32'(bus.mem_en),   0);
        check("rst_mem_we",   32'(bus.mem_we),   0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        @(posedge clk); #1;
        rst = 1'b0; bus.i_req = 1'b0; bus.d_req = 1'b0;

        // fetch only
        bus.i_req = 1'b1; bus.i_addr = 10'h010;
        #1;
        check("f_mem_addr", 32'(bus.mem_addr), 32'h010);
        cycle(1, 0, 0, "fetch");
        bus.i_req = 1'b0;
        repeat (3) cycle(0, 0, 0, "fetch_wait");

        // partial store then load back
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'h020;
        bus.d_be = 4'b0011; bus.d_wdata = 32'hAABB_CCDD;
        #1;
        check("st_mem_we", 32'(bus.mem_we), 1);
        check("st_mem_be", 32'(bus.mem_be), 32'h3);
        cycle(0, 1, 0, "store");
        bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_wdata = '0;
        cycle(0, 1, 32'h1122_CCDD, "load");
        bus.d_req = 1'b0;
        repeat (4) cycle(0, 0, 0, "ld_wait");
        check("i_rdata_hold", bus.i_rdata, 32'h0050_0093);

        // continuous contention
        bus.i_req = 1'b1; bus.i_addr = 10'h101;
        bus.d_req = 1'b1; bus.d_addr = 10'h200;
        for (int n = 0; n < 10; n++) begin
`ifdef MEM_PORT_ARBITER_RR_EN
            gi = (n % 2 == 0);
`else
            gi = (n % 5 == 4);
`endif
            cycle(gi, !gi, pat(bus.d_addr), "cont");
            if (gi) bus.i_addr = bus.i_addr + 10'd1;
            else    bus.d_addr = bus.d_addr + 10'd1;
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        repeat (4) cycle(0, 0, 0, "cont_drain");

        // reset with two reads in flight
        bus.i_req = 1'b1; bus.i_addr = 10'h030;
        cycle(1, 0, 0, "rf_fetch");
        bus.i_req = 1'b0; bus.d_req = 1'b1; bus.d_addr = 10'h031;
        cycle(0, 1, pat(10'h031), "rf_data");
        bus.d_req = 1'b0;
        rst = 1'b1;
        expq.delete();
        repeat (2) cycle(0, 0, 0, "rf_inrst");
        rst = 1'b0;
        repeat (5) cycle(0, 0, 0, "rf_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
